// File: rtl/cpu_ctrl_pkg.sv
// cpu_ctrl_pkg: shared state encoding and widths for the pipeline stall controller
package cpu_ctrl_pkg;
   typedef enum logic {RUN = 1'b0, MEM_WAIT = 1'b1} state_t;
   localparam int WAIT_W = 4;
endpackage

// File: rtl/pipeline_stall_ctrl_if.sv
// pipeline_stall_ctrl_if: hazard requests in, pipeline stage controls out
interface pipeline_stall_ctrl_if #(parameter int CNT_W = 16);
   logic             hz_stall;
   logic             br_taken;
   logic             mem_start;
   logic             pc_en;
   logic             ifid_en;
   logic             ifid_flush;
   logic             idex_bubble;
   logic             back_en;
   logic             mem_busy;
   logic [CNT_W-1:0] stall_cnt;
   modport master (output hz_stall, br_taken, mem_start,
                   input pc_en, ifid_en, ifid_flush, idex_bubble, back_en, mem_busy, stall_cnt);
   modport slave (input hz_stall, br_taken, mem_start,
                  output pc_en, ifid_en, ifid_flush, idex_bubble, back_en, mem_busy, stall_cnt);
endinterface

// File: rtl/sat_counter.sv
// sat_counter: up-counter that sticks at all-ones, cleared synchronously
module sat_counter #(parameter int CNT_W = 16) (
   input  logic             clk,
   input  logic             clr_i,
   input  logic             inc_i,
   output logic [CNT_W-1:0] cnt_o
);
   logic [CNT_W-1:0] cnt_q;
   assign cnt_o = cnt_q;
   // count up on inc unless already saturated
   always_ff @(posedge clk)
      cnt_q <= clr_i ? '0 : (inc_i && !(&cnt_q)) ? cnt_q + CNT_W'(1) : cnt_q;
endmodule

// File: rtl/pipeline_stall_ctrl.sv
// pipeline_stall_ctrl: stage enables/flush/bubble with multi-cycle memory freeze
module pipeline_stall_ctrl
   import cpu_ctrl_pkg::*;
#(
   parameter int MEM_LAT = 3,
   parameter int CNT_W   = 16
) (
   input logic                 clk,
   input logic                 reset,
   pipeline_stall_ctrl_if.slave bus
);
   state_t            state_q, state_d;
   logic [WAIT_W-1:0] wait_q, wait_d;
   logic              frz, start, hold;
   // next state and Mealy output decode; mem_start is only honoured in RUN
   always_comb begin
      frz             = state_q == MEM_WAIT && wait_q != '0;
      start           = state_q == RUN && bus.mem_start;
      hold            = start || frz;
      state_d         = hold ? MEM_WAIT : RUN;
      wait_d          = start ? WAIT_W'(MEM_LAT) : frz ? wait_q - WAIT_W'(1) : wait_q;
      bus.pc_en       = !reset && !hold && !bus.hz_stall;
      bus.ifid_en     = !reset && !hold && !bus.hz_stall;
      bus.ifid_flush  = reset || (!hold && !bus.hz_stall && bus.br_taken);
      bus.idex_bubble = reset || (!hold && bus.hz_stall);
      bus.back_en     = reset || !hold;
      bus.mem_busy    = !reset && state_q == MEM_WAIT;
   end
   // FSM state and freeze down-counter
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= RUN;
         wait_q  <= '0;
      end else begin
         state_q <= state_d;
         wait_q  <= wait_d;
      end
   end
   sat_counter #(.CNT_W(CNT_W)) u_cnt (
      .clk   (clk),
      .clr_i (reset),
      .inc_i (!bus.pc_en),
      .cnt_o (bus.stall_cnt)
   );
endmodule
